// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised UART receiver with 3-sample majority voting, framing-error and break detection.
// Define UART_RX_PARITY_EN to expect one parity bit after the data bits and report mismatches.
module uart_rx_ext #(
    parameter int unsigned CLKS_PER_BIT = 46,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_N,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = 4;
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_rx_ext: CLKS_PER_BIT must be 8..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_rx_ext: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_ext: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_rx_ext: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state, state_n;
    logic                 sync1, sync2;
    logic [2:0]           hist;
    logic                 maj;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 ferr, ferr_n;
    logic                 par_low;
    logic                 dv_n, fe_n, brk_n;
    logic [DATA_BITS-1:0] byte_n;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_n;
    logic                 pe_q, pe_n;
`endif

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= '1;
        end else begin
            sync1 <= i_Rx_Serial;
            sync2 <= sync1;
            hist  <= {hist[1:0], sync2};
        end
    end

    assign maj = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

`ifdef UART_RX_PARITY_EN
    assign par_low = ~par_bit;
`else
    assign par_low = 1'b1;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        ferr_n  = ferr;
        dv_n    = 1'b0;
        byte_n  = o_Rx_Byte;
        fe_n    = o_Frame_Err;
        brk_n   = o_Break;
`ifdef UART_RX_PARITY_EN
        par_n   = par_bit;
        pe_n    = pe_q;
`endif
        case (state)
            S_IDLE: begin
                if (!sync2) begin
                    cnt_n   = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    ferr_n  = 1'b0;
                    state_n = maj ? S_IDLE : S_DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shreg_n = {maj, shreg[DATA_BITS-1:1]};
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        idx_n = '0;
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    par_n   = maj;
                    state_n = S_STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (!maj) ferr_n = 1'b1;
                    // Frame completes at the centre of the last stop bit so IDLE is back before the next start edge.
                    if (idx == IDX_W'(STOP_BITS - 1)) begin
                        dv_n    = 1'b1;
                        byte_n  = shreg;
                        fe_n    = ferr | ~maj;
                        brk_n   = (shreg == '0) & par_low & ~maj;
`ifdef UART_RX_PARITY_EN
                        pe_n    = ((^shreg) ^ par_bit) != 1'(PARITY_ODD);
`endif
                        state_n = brk_n ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (sync2) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            ferr        <= 1'b0;
            o_Rx_DV     <= 1'b0;
            o_Rx_Byte   <= '0;
            o_Frame_Err <= 1'b0;
            o_Break     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            pe_q        <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            ferr        <= ferr_n;
            o_Rx_DV     <= dv_n;
            o_Rx_Byte   <= byte_n;
            o_Frame_Err <= fe_n;
            o_Break     <= brk_n;
`ifdef UART_RX_PARITY_EN
            par_bit     <= par_n;
            pe_q        <= pe_n;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign o_Parity_Err = pe_q;
`else
    assign o_Parity_Err = 1'b0;
`endif

    assign o_Busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: randomized and directed serial frames; expected words/flags queued per frame and
// popped by a monitor on every o_Rx_DV strobe.
`timescale 1ns/1ps
module tb_uart_rx_ext;

    localparam int CPB  = 16;
    localparam int DW   = 8;
    localparam int SB   = 1;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = (1 + DW + PB + SB) * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          dv, fe, pe, brk, busy;
    logic [DW-1:0] word;

    uart_rx_ext #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DW),
        .STOP_BITS   (SB),
        .PARITY_ODD  (PODD)
    ) dut (
        .i_Clock     (clk),
        .i_Reset_N   (rst_n),
        .i_Rx_Serial (rx),
        .o_Rx_DV     (dv),
        .o_Rx_Byte   (word),
        .o_Frame_Err (fe),
        .o_Parity_Err(pe),
        .o_Break     (brk),
        .o_Busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] w;
        logic          fe;
        logic          pe;
        logic          brk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   strobes = 0;
    int   cyc = 0;
    int   strobe_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && dv) begin
            strobes++;
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got word 0x%0h, expected no strobe", word);
            end else begin
                e = exp_q.pop_front();
                chk("word",       32'(word), 32'(e.w));
                chk("frame_err",  32'(fe),   32'(e.fe));
                chk("parity_err", 32'(pe),   32'(e.pe));
                chk("break",      32'(brk),  32'(e.brk));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic good_par(input logic [DW-1:0] d);
        return (^d) ^ 1'(PODD);
    endfunction

    // Reference: word as sent; framing error iff the stop bit is low; break iff everything incl. stop is low.
    task automatic expect_frame(input logic [DW-1:0] d, input logic par, input bit stop_bad);
        exp_t e;
        e.w   = d;
        e.fe  = stop_bad;
        e.pe  = (PB != 0) ? (((^d) ^ par) != 1'(PODD)) : 1'b0;
        e.brk = stop_bad && (d == '0) && (PB == 0 || !par);
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        for (int c = 0; c < CPB; c++) begin
            rx = (glitch && c == CPB / 2 - 3) ? ~v : v;
            step();
        end
    endtask

    // A bad stop bit is held low past its centre then released, so the tail is too short to pass as a start.
    task automatic send_frame(input logic [DW-1:0] d, input logic par, input bit stop_bad,
                              input int glitch_bit, input bit lat);
        expect_frame(d, par, stop_bad);
        for (int c = 0; c < CPB; c++) begin
            rx = 1'b0;
            if (lat && c == 2) chk("busy_before_start", 32'(busy), 32'd0);
            if (lat && c == 3) chk("busy_start_entry",  32'(busy), 32'd1);
            step();
        end
        for (int b = 0; b < DW; b++) send_bit(d[b], b == glitch_bit);
        if (PB != 0) send_bit(par, 1'b0);
        for (int s = 0; s < SB; s++) begin
            if (stop_bad && s == SB - 1) begin
                for (int c = 0; c < CPB; c++) begin
                    rx = (c < CPB / 2 + 2) ? 1'b0 : 1'b1;
                    step();
                end
            end else begin
                send_bit(1'b1, 1'b0);
            end
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) step();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2 * FRAME) begin
            step();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        logic [DW-1:0] d;
        logic p;

        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) step();
        chk("reset_dv",    32'(dv),   32'd0);
        chk("reset_word",  32'(word), 32'd0);
        chk("reset_fe",    32'(fe),   32'd0);
        chk("reset_pe",    32'(pe),   32'd0);
        chk("reset_brk",   32'(brk),  32'd0);
        chk("reset_busy",  32'(busy), 32'd0);
        rst_n = 1'b1;
        idle(4);
        chk("idle_busy", 32'(busy), 32'd0);

        send_frame(8'hA5, good_par(8'hA5), 1'b0, -1, 1'b1);
        drain("drain_a5");
        idle(2 * CPB);

        // Zero-gap frames strobe exactly one frame period apart.
        s0 = strobes;
        send_frame(8'h00, good_par(8'h00), 1'b0, -1, 1'b0);
        send_frame(8'hFF, good_par(8'hFF), 1'b0, -1, 1'b0);
        drain("drain_b2b");
        chk("b2b_strobes", 32'(strobes - s0), 32'd2);
        if (strobes - s0 == 2)
            chk("b2b_spacing", 32'(strobe_cyc[strobe_cyc.size()-1] - strobe_cyc[strobe_cyc.size()-2]),
                32'(FRAME));
        idle(2 * CPB);

        send_frame(8'h3C, good_par(8'h3C), 1'b1, -1, 1'b0);
        drain("drain_frame_err");
        idle(3 * CPB);

        s0 = strobes;
        expect_frame(8'h00, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (20 * CPB) step();
        chk("break_strobes", 32'(strobes - s0), 32'd1);
        chk("break_busy_low_line", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (3) step();
        chk("break_released_busy", 32'(busy), 32'd0);
        idle(CPB);
        send_frame(8'h5A, good_par(8'h5A), 1'b0, -1, 1'b0);
        drain("drain_after_break");
        idle(2 * CPB);

        s0 = strobes;
        rx = 1'b0;
        step();
        idle(2 * CPB);
        rx = 1'b0;
        repeat (5) step();
        idle(3 * CPB);
        chk("glitch_no_strobe", 32'(strobes - s0), 32'd0);

        send_frame(8'h81, good_par(8'h81), 1'b0, 1, 1'b0);
        drain("drain_glitch_data");
        idle(2 * CPB);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b0, -1, 1'b0);
        drain("drain_par_bad");
        idle(2 * CPB);
        send_frame(8'h07, 1'b1, 1'b0, -1, 1'b0);
        drain("drain_par_good");
        idle(2 * CPB);
`endif

        for (int i = 0; i < 24; i++) begin
            d = DW'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
            send_frame(d, p, 1'b0, -1, 1'b0);
            idle($urandom_range(0, 2 * CPB));
        end
        drain("drain_random");
        idle(2 * CPB);

        // Reset in the middle of a frame discards it.
        s0 = strobes;
        rx = 1'b0;
        repeat (CPB) step();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("midframe_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_busy_async", 32'(busy), 32'd0);
        chk("reset_word_async", 32'(word), 32'd0);
        rx = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        idle(2 * FRAME);
        chk("reset_no_strobe", 32'(strobes - s0), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
